mdu: RTL and testbench

Multiply/divide unit for the P5/P6 pipelined MIPS core, sitting in the E stage beside the ALU and fed the same forwarded operands `SRCA`/`SRCB`. It executes MULT/MULTU/DIV/DIVU as fixed multi-cycle operations, owns the HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO. Its `busy` output drives the hazard unit, which stalls any MD-class instruction in D while an operation is in flight. `MDUresult` is muxed with `ALUresult` into the E/M pipeline register.

---
 rtl/mdu.sv | 79 +++++++
 tb/tb_mdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO/MFHI/MFLO access
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic [3:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
  logic last, acc, is_mul, is_div, sgn;
  logic [63:0] ea, eb, prod;
  logic [31:0] ua, ub, q, r, qs, rs, phi, plo;
  always_comb begin
    is_mul = MDUop == 4'd1 || MDUop == 4'd2;
    is_div = MDUop == 4'd3 || MDUop == 4'd4;
    sgn = MDUop == 4'd1 || MDUop == 4'd3;
    ea = {{32{sgn & SRCA[31]}}, SRCA};
    eb = {{32{sgn & SRCB[31]}}, SRCB};
    prod = ea * eb;
    // divide on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no special case
    ua = sgn && SRCA[31] ? -SRCA : SRCA;
    ub = sgn && SRCB[31] ? -SRCB : SRCB;
    q = ub == 32'd0 ? 32'd0 : ua / ub;
    r = ub == 32'd0 ? 32'd0 : ua % ub;
    qs = sgn && (SRCA[31] ^ SRCB[31]) ? -q : q;
    rs = sgn && SRCA[31] ? -r : r;
    last = state_q == RUN && cnt_q == CW'(1);
    // the final RUN cycle also accepts a new op, giving back-to-back issue
    acc = start && (state_q == IDLE || last);
    phi = last ? thi_q : hi_q;
    plo = last ? tlo_q : lo_q;
    state_d = last ? IDLE : state_q;
    cnt_d = state_q == RUN ? cnt_q - CW'(1) : cnt_q;
    hi_d = acc && MDUop == 4'd5 ? SRCA : phi;
    lo_d = acc && MDUop == 4'd6 ? SRCA : plo;
    thi_d = thi_q;
    tlo_d = tlo_q;
    if (acc && (is_mul || is_div)) begin
      state_d = RUN;
      cnt_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      thi_d = is_mul ? prod[63:32] : ub == 32'd0 ? phi : rs;
      tlo_d = is_mul ? prod[31:0] : ub == 32'd0 ? plo : qs;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      thi_q <= '0;
      tlo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
    end
  end
  assign busy = state_q == RUN;
  assign HI = hi_q;
  assign LO = lo_q;
  assign MDUresult = MDUop == 4'd7 ? hi_q : MDUop == 4'd8 ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu against a plain-arithmetic HI/LO model
module tb_mdu;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, busy;
  logic [31:0] SRCA = '0, SRCB = '0, HI, LO, MDUresult;
  logic [3:0] MDUop = '0;
  int checks = 0, errors = 0, cyc = 0, busy_end = 0;
  logic [31:0] ehi = '0, elo = '0, mhi = '0, mlo = '0;
  typedef struct {
    int acc;
    int due;
    bit md;
    bit whi;
    bit wlo;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;
  ent_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .SRCA(SRCA), .SRCB(SRCB), .MDUop(MDUop),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUresult(MDUresult)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // monitor: retire due entries into the expected architectural state, then compare
  always @(negedge clk) begin
    if (reset_n) begin
      logic eb;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        if (sb[0].whi) ehi = sb[0].hi;
        if (sb[0].wlo) elo = sb[0].lo;
        void'(sb.pop_front());
      end
      eb = 1'b0;
      foreach (sb[i]) if (sb[i].md && sb[i].acc <= cyc) eb = 1'b1;
      chk("busy", 32'(busy), 32'(eb));
      chk("HI", HI, ehi);
      chk("LO", LO, elo);
      chk("MDUresult", MDUresult, MDUop == 4'd7 ? ehi : MDUop == 4'd8 ? elo : 32'd0);
    end
  end

  function automatic logic [3:0] rd();
    int k = $urandom_range(0, 3);
    return k == 0 ? 4'd0 : k == 1 ? 4'd7 : k == 2 ? 4'd8 : 4'd11;
  endfunction

  function automatic logic [31:0] rop();
    int k = $urandom_range(0, 7);
    return k == 0 ? 32'd0 : k == 1 ? 32'd1 : k == 2 ? 32'hFFFFFFFF :
           k == 3 ? 32'h80000000 : k == 4 ? 32'h7FFFFFFF : $urandom;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      MDUop = rd();
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    longint p;
    longint unsigned pu;
    int sa, sbv;
    e.acc = cyc + 1;
    e.md = 1'b0;
    e.whi = 1'b0;
    e.wlo = 1'b0;
    e.hi = mhi;
    e.lo = mlo;
    MDUop = op;
    SRCA = a;
    SRCB = b;
    start = 1'b1;
    if (e.acc >= busy_end && op >= 4'd1 && op <= 4'd6) begin
      sa = a;
      sbv = b;
      e.md = op <= 4'd4;
      e.whi = op != 4'd6;
      e.wlo = op != 4'd5;
      e.due = e.acc + (op <= 4'd2 ? 5 : op <= 4'd4 ? 10 : 0);
      if (op == 4'd1) begin
        p = longint'(sa) * longint'(sbv);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end else if (op == 4'd2) begin
        pu = {32'd0, a} * {32'd0, b};
        e.hi = pu[63:32];
        e.lo = pu[31:0];
      end else if (op == 4'd3 && b != 0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.lo = 32'h80000000;
          e.hi = 32'd0;
        end else begin
          e.lo = sa / sbv;
          e.hi = sa % sbv;
        end
      end else if (op == 4'd4 && b != 0) begin
        e.lo = a / b;
        e.hi = a % b;
      end else if (op == 4'd5) e.hi = a;
      else if (op == 4'd6) e.lo = a;
      mhi = e.hi;
      mlo = e.lo;
      if (e.md) busy_end = e.due;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    MDUop = rd();
  endtask

  task automatic wait_idle();
    while (cyc + 1 < busy_end) step(1);
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(2);
    issue(4'd6, 32'h55, 0);
    issue(4'd5, 32'h66, 0);
    issue(4'd1, 32'd3, 32'd4);
    step(2);
    reset_n = 1'b0;
    sb.delete();
    ehi = '0; elo = '0; mhi = '0; mlo = '0; busy_end = 0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    step(1);
    reset_n = 1'b1;
    step(12);
    issue(4'd1, 32'hFFFFFFFF, 32'd2); wait_idle(); step(1);
    chk("mult_HI", mhi, 32'hFFFFFFFF); chk("mult_LO", mlo, 32'hFFFFFFFE);
    issue(4'd2, 32'hFFFFFFFF, 32'd2); wait_idle(); step(1);
    chk("multu_HI", mhi, 32'd1); chk("multu_LO", mlo, 32'hFFFFFFFE);
    issue(4'd3, -32'sd7, 32'd2); wait_idle(); step(1);
    chk("div_HI", mhi, 32'hFFFFFFFF); chk("div_LO", mlo, 32'hFFFFFFFD);
    issue(4'd4, 32'd7, 32'd2); wait_idle(); step(1);
    chk("divu_HI", mhi, 32'd1); chk("divu_LO", mlo, 32'd3);
    issue(4'd5, 32'h1234, 0);
    issue(4'd6, 32'h5678, 0);
    issue(4'd4, 32'd99, 32'd0); wait_idle(); step(1);
    chk("div0_HI", mhi, 32'h1234); chk("div0_LO", mlo, 32'h5678);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle(); step(1);
    chk("ovf_HI", mhi, 32'd0); chk("ovf_LO", mlo, 32'h80000000);
    issue(4'd1, 32'd5, 32'd6);
    issue(4'd6, 32'hAAAA, 0);
    MDUop = 4'd8;
    wait_idle();
    step(1);
    chk("mtlo_ignored", mlo, 32'd30);
    issue(4'd1, 32'h1234567, 32'h89ABCDE);
    wait_idle();
    issue(4'd1, 32'hDEADBEEF, 32'h12345);
    wait_idle();
    issue(4'd3, 32'hF0000001, 32'h7);
    wait_idle();
    issue(4'd5, 32'hCAFE, 0);
    wait_idle();
    step(2);
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), rop(), rop());
      step($urandom_range(0, 12));
    end
    wait_idle();
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
